// File: rtl/featuremap_pkg.sv
// Shared types and constants for the padded feature-map writer.
// FSM state encoding and the IEEE-754 zero word used for padding.
package featuremap_pkg;

   typedef enum logic [2:0] {
      IDLE,
      TOP,
      LEFT,
      DATA,
      RIGHT,
      BOTTOM,
      DONE
   } fm_state_t;

   localparam logic [31:0] FP32_ZERO = 32'h0000_0000;

endpackage

// File: rtl/featuremap_pos_counter.sv
// Column/row position tracker for the padded output frame.
// Advances only on written words; column wraps at the row end.
module featuremap_pos_counter
   import featuremap_pkg::*;
#(
   parameter int WIDTH = 56,
   localparam int CW = $clog2(WIDTH + 2)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          adv,
   input  logic          clr,
   output logic [CW-1:0] col,
   output logic [CW-1:0] row,
   output logic          row_end,
   output logic          last
);

   localparam logic [CW-1:0] EDGE = CW'(WIDTH + 1);

   assign row_end = (col == EDGE);
   assign last    = row_end && (row == EDGE);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         col <= '0;
         row <= '0;
      end else if (adv) begin
         if (row_end) begin
            col <= '0;
            row <= last ? '0 : row + CW'(1);
         end else begin
            col <= col + CW'(1);
         end
      end
   end

endmodule

// File: rtl/featuremap_pad_writer.sv
// Streams a WIDTH x WIDTH map into a FIFO as a zero-padded
// (WIDTH+2) x (WIDTH+2) frame, stalling on fifo_full.
module featuremap_pad_writer
   import featuremap_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int WIDTH      = 56
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  valid_in,
   output logic                  ready_out,
   input  logic                  fifo_full,
   output logic                  wrreq,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  busy,
   output logic                  frame_done
);

   localparam int CW = $clog2(WIDTH + 2);
   localparam logic [DATA_WIDTH-1:0] PAD = DATA_WIDTH'(FP32_ZERO);

   fm_state_t       state, state_n;
   logic [CW-1:0]   col, row;
   logic            row_end, last;
   logic            clr;

   featuremap_pos_counter #(
      .WIDTH (WIDTH)
   ) u_pos (
      .clk     (clk),
      .rst     (rst),
      .adv     (wrreq),
      .clr     (clr),
      .col     (col),
      .row     (row),
      .row_end (row_end),
      .last    (last)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n   = state;
      wrreq     = 1'b0;
      ready_out = 1'b0;
      data_out  = PAD;
      unique case (state)
         IDLE: begin
            if (start) state_n = TOP;
         end
         TOP: begin
            wrreq = ~fifo_full;
            if (wrreq && row_end) state_n = LEFT;
         end
         LEFT: begin
            wrreq = ~fifo_full;
            if (wrreq) state_n = DATA;
         end
         DATA: begin
            ready_out = ~fifo_full;
            wrreq     = valid_in & ~fifo_full;
            data_out  = data_in;
            if (wrreq && col == CW'(WIDTH)) state_n = RIGHT;
         end
         RIGHT: begin
            wrreq = ~fifo_full;
            if (wrreq)
               state_n = (row == CW'(WIDTH)) ? BOTTOM : LEFT;
         end
         BOTTOM: begin
            wrreq = ~fifo_full;
            if (wrreq && last) state_n = DONE;
         end
         DONE: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
      // Reset silences the outputs in the same cycle, not one edge later.
      if (rst) begin
         wrreq     = 1'b0;
         ready_out = 1'b0;
         data_out  = PAD;
      end
   end

   assign clr        = (state == IDLE) || (state == DONE);
   assign busy       = (state != IDLE) && !rst;
   assign frame_done = (state == DONE) && !rst;

endmodule
